// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the two-client RAM port arbiter.
// Holds the default RAM geometry, the client tag and the client request bundle.
package ram_arb_pkg;

  localparam int AW = 12;
  localparam int DW = 64;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_id_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ram_req_t;

  // Read-after-write hazard compare between a read address and the write being granted
  function automatic logic addr_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client request/response and RAM-side signals of the RAM port arbiter.
// slave = arbiter side, master = clients plus RAM side.
interface ram_port_arbiter_if #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW
);

  logic          c0_req;
  logic          c0_we;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c0_gnt;
  logic          c0_rvalid;
  logic [DW-1:0] c0_rdata;

  logic          c1_req;
  logic          c1_we;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic          c1_gnt;
  logic          c1_rvalid;
  logic [DW-1:0] c1_rdata;

  logic          write;
  logic [AW-1:0] wrt_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output write, wrt_address, data_in,
    output read, rd_address,
    input  data_out
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  write, wrt_address, data_in,
    input  read, rd_address,
    output data_out
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-request round-robin picker: on contention the client not granted last wins.
// The pointer only moves when a grant is issued; after reset client 0 wins first.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       srst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  client_id_e last_r;

  // Grant selection from the requests and the last-granted pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_r == CLIENT0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Last-granted pointer, reset to client 1 so client 0 wins the first tie
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_r <= CLIENT1;
    end else if (srst) begin
      last_r <= CLIENT1;
    end else if (gnt[0]) begin
      last_r <= CLIENT0;
    end else if (gnt[1]) begin
      last_r <= CLIENT1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter onto a RAM with separate write and read ports.
// Each port is round-robin arbitrated on its own; a read hitting the address being written this cycle waits.
module ram_port_arbiter #(
  parameter int AW = ram_arb_pkg::AW,
  parameter int DW = ram_arb_pkg::DW
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  srst,
  ram_port_arbiter_if.slave     bus
);

  import ram_arb_pkg::*;

  logic          req_en_s;
  ram_req_t      c0_s;
  ram_req_t      c1_s;
  logic [1:0]    wr_req_s;
  logic [1:0]    wr_gnt_s;
  logic          wr_any_s;
  ram_req_t      wr_sel_s;
  logic [1:0]    rd_req_s;
  logic [1:0]    rd_gnt_s;
  logic          rd_any_s;
  logic [AW-1:0] rd_addr_s;
  client_id_e    rd_owner_s;

  logic          write_r;
  logic [AW-1:0] wrt_address_r;
  logic [DW-1:0] data_in_r;
  logic          read_r;
  logic [AW-1:0] rd_address_r;
  client_id_e    rd_owner_r;
  logic [1:0]    rvalid_r;
  logic [DW-1:0] rdata_hold0_r;
  logic [DW-1:0] rdata_hold1_r;

  assign req_en_s = resetn & ~srst;

  // Bundle client inputs and form write-port requests
  always_comb begin
    c0_s     = '{we: bus.c0_we, addr: bus.c0_addr, wdata: bus.c0_wdata};
    c1_s     = '{we: bus.c1_we, addr: bus.c1_addr, wdata: bus.c1_wdata};
    wr_req_s = 2'b00;
    if (req_en_s) begin
      wr_req_s = {bus.c1_req & c1_s.we, bus.c0_req & c0_s.we};
    end else begin
      wr_req_s = 2'b00;
    end
  end

  rr_arb2 u_wr_arb (
    .clock  (clock),
    .resetn (resetn),
    .srst   (srst),
    .req    (wr_req_s),
    .gnt    (wr_gnt_s)
  );

  // Winning write request, and read requests masked by the same-address hazard
  always_comb begin
    wr_any_s = |wr_gnt_s;
    if (wr_gnt_s[1]) begin
      wr_sel_s = c1_s;
    end else begin
      wr_sel_s = c0_s;
    end
    rd_req_s = 2'b00;
    if (req_en_s) begin
      rd_req_s[0] = bus.c0_req & ~c0_s.we & ~(wr_any_s & addr_match(c0_s.addr, wr_sel_s.addr));
      rd_req_s[1] = bus.c1_req & ~c1_s.we & ~(wr_any_s & addr_match(c1_s.addr, wr_sel_s.addr));
    end else begin
      rd_req_s = 2'b00;
    end
  end

  rr_arb2 u_rd_arb (
    .clock  (clock),
    .resetn (resetn),
    .srst   (srst),
    .req    (rd_req_s),
    .gnt    (rd_gnt_s)
  );

  // Winning read address and its owner tag
  always_comb begin
    rd_any_s = |rd_gnt_s;
    if (rd_gnt_s[1]) begin
      rd_addr_s  = c1_s.addr;
      rd_owner_s = CLIENT1;
    end else begin
      rd_addr_s  = c0_s.addr;
      rd_owner_s = CLIENT0;
    end
  end

  assign bus.c0_gnt = wr_gnt_s[0] | rd_gnt_s[0];
  assign bus.c1_gnt = wr_gnt_s[1] | rd_gnt_s[1];

  // RAM strobe stage plus read-return stage; reset drops any read still in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      write_r       <= 1'b0;
      wrt_address_r <= '0;
      data_in_r     <= '0;
      read_r        <= 1'b0;
      rd_address_r  <= '0;
      rd_owner_r    <= CLIENT0;
      rvalid_r      <= 2'b00;
      rdata_hold0_r <= '0;
      rdata_hold1_r <= '0;
    end else if (srst) begin
      write_r       <= 1'b0;
      wrt_address_r <= '0;
      data_in_r     <= '0;
      read_r        <= 1'b0;
      rd_address_r  <= '0;
      rd_owner_r    <= CLIENT0;
      rvalid_r      <= 2'b00;
      rdata_hold0_r <= '0;
      rdata_hold1_r <= '0;
    end else begin
      write_r <= wr_any_s;
      if (wr_any_s) begin
        wrt_address_r <= wr_sel_s.addr;
        data_in_r     <= wr_sel_s.wdata;
      end
      read_r <= rd_any_s;
      if (rd_any_s) begin
        rd_address_r <= rd_addr_s;
        rd_owner_r   <= rd_owner_s;
      end
      rvalid_r[0] <= read_r & (rd_owner_r == CLIENT0);
      rvalid_r[1] <= read_r & (rd_owner_r == CLIENT1);
      if (rvalid_r[0]) begin
        rdata_hold0_r <= bus.data_out;
      end
      if (rvalid_r[1]) begin
        rdata_hold1_r <= bus.data_out;
      end
    end
  end

  assign bus.write       = write_r;
  assign bus.wrt_address = wrt_address_r;
  assign bus.data_in     = data_in_r;
  assign bus.read        = read_r;
  assign bus.rd_address  = rd_address_r;
  assign bus.c0_rvalid   = rvalid_r[0];
  assign bus.c1_rvalid   = rvalid_r[1];
  // RAM data arrives in the rvalid cycle itself, so it is passed through then and held afterwards
  assign bus.c0_rdata    = rvalid_r[0] ? bus.data_out : rdata_hold0_r;
  assign bus.c1_rdata    = rvalid_r[1] ? bus.data_out : rdata_hold1_r;

endmodule
